// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types for the mm:ss stopwatch controller: FSM states, edit field,
// button pulse bundle and the one-hot priority decode applied to it.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ADJ   = 2'd3
    } state_t;

    typedef enum logic {
        FIELD_SEC = 1'b0,
        FIELD_MIN = 1'b1
    } field_t;

    localparam int BLANK_TENS_MIN = 3;
    localparam int BLANK_ONES_MIN = 2;
    localparam int BLANK_TENS_SEC = 1;
    localparam int BLANK_ONES_SEC = 0;

    typedef struct packed {
        logic clear;
        logic adjust;
        logic start_stop;
        logic sel;
        logic inc;
    } pulses_t;

    function automatic logic [3:0] field_mask(field_t f);
        logic [3:0] m;
        m = '0;
        if (f == FIELD_MIN) begin
            m[BLANK_TENS_MIN] = 1'b1;
            m[BLANK_ONES_MIN] = 1'b1;
        end else begin
            m[BLANK_TENS_SEC] = 1'b1;
            m[BLANK_ONES_SEC] = 1'b1;
        end
        return m;
    endfunction

    // Keep only the highest-priority pulse; everything below it is dropped.
    function automatic pulses_t prio_decode(pulses_t raw);
        pulses_t d;
        d = '0;
        if (raw.clear)           d.clear      = 1'b1;
        else if (raw.adjust)     d.adjust     = 1'b1;
        else if (raw.start_stop) d.start_stop = 1'b1;
        else if (raw.sel)        d.sel        = 1'b1;
        else if (raw.inc)        d.inc        = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, display digits/blank/status out. The button side is the
// master; the controller is the slave.
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       clear;
    logic       adjust;
    logic       sel;
    logic       inc;
    logic [3:0] tens_minutes;
    logic [3:0] ones_minutes;
    logic [3:0] tens_seconds;
    logic [3:0] ones_seconds;
    logic [3:0] blank;
    logic       running;
    logic       rollover;

    modport master (
        output start_stop, clear, adjust, sel, inc,
        input  tens_minutes, ones_minutes, tens_seconds, ones_seconds,
        input  blank, running, rollover
    );

    modport slave (
        input  start_stop, clear, adjust, sel, inc,
        output tens_minutes, ones_minutes, tens_seconds, ones_seconds,
        output blank, running, rollover
    );
endinterface

// File: rtl/stopwatch_ctrl_bcd_pair_counter.sv
// Two-digit BCD counter 00..LIMIT with synchronous clear (dominant over inc)
// and a combinational wrap flag raised on the inc that returns it to 00.
module stopwatch_ctrl_bcd_pair_counter #(
    parameter int LIMIT = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);
    localparam logic [3:0] LIM_TENS = 4'(LIMIT / 10);
    localparam logic [3:0] LIM_ONES = 4'(LIMIT % 10);

    logic at_limit;

    assign at_limit = (tens == LIM_TENS) && (ones == LIM_ONES);
    assign wrap     = inc && !clr && at_limit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_limit) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == 4'd9) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/adjust controller for the mm:ss stopwatch: FSM, 1 s prescaler,
// adjust-mode blink timer and the two BCD field counters.
//
//    state | meaning
//    ------+---------------------------------------------------
//    IDLE  | stopped after reset or clear, prescaler at 0
//    RUN   | prescaler counting, time advances every second
//    PAUSE | time and prescaler frozen
//    ADJ   | time frozen, inc/sel edit the blinking field
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 1000,
    parameter int BLINK_HALF = 250,
    parameter int MAX_MIN    = 59
) (
    input logic              clk,
    input logic              reset,
    stopwatch_ctrl_if.slave  bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

    state_t        state;
    field_t        field;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          blink_odd;
    logic [3:0]    blank;
    logic          running;
    logic          rollover;

    pulses_t raw, act;
    logic    in_adj, sec_tick, sec_inc, sec_wrap, min_inc, min_wrap;
    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;

    assign raw      = {bus.clear, bus.adjust, bus.start_stop, bus.sel, bus.inc};
    assign act      = prio_decode(raw);
    assign in_adj   = (state == ST_ADJ);
    assign sec_tick = (state == ST_RUN) && (presc == PRESC_LAST);

    // Field carries only come from real time; ADJ edits never cascade.
    assign sec_inc = sec_tick || (in_adj && act.inc && field == FIELD_SEC);
    assign min_inc = (sec_wrap && !in_adj) || (in_adj && act.inc && field == FIELD_MIN);

    stopwatch_ctrl_bcd_pair_counter #(.LIMIT(59)) u_sec (
        .clk  (clk),
        .reset(reset),
        .inc  (sec_inc),
        .clr  (act.clear),
        .tens (sec_tens),
        .ones (sec_ones),
        .wrap (sec_wrap)
    );

    stopwatch_ctrl_bcd_pair_counter #(.LIMIT(MAX_MIN)) u_min (
        .clk  (clk),
        .reset(reset),
        .inc  (min_inc),
        .clr  (act.clear),
        .tens (min_tens),
        .ones (min_ones),
        .wrap (min_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            field     <= FIELD_SEC;
            presc     <= '0;
            blink_cnt <= '0;
            blink_odd <= 1'b0;
            blank     <= '0;
            running   <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            rollover <= min_wrap && !in_adj;
            case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (act.clear) begin
                        state <= ST_IDLE;
                        presc <= '0;
                    end else if (act.adjust) begin
                        state     <= ST_ADJ;
                        field     <= FIELD_SEC;
                        blink_cnt <= BLINK_LOAD;
                        blink_odd <= 1'b0;
                        blank     <= '0;
                    end else if (act.start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (act.clear) begin
                        state   <= ST_IDLE;
                        running <= 1'b0;
                        presc   <= '0;
                    end else begin
                        // Pausing freezes the prescaler at its current phase.
                        if (sec_tick)
                            presc <= '0;
                        else if (!act.start_stop)
                            presc <= presc + 1'b1;
                        if (act.start_stop) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                end
                ST_ADJ: begin
                    if (act.adjust) begin
                        state <= ST_PAUSE;
                        blank <= '0;
                    end else if (act.sel || act.inc) begin
                        if (act.sel)
                            field <= (field == FIELD_SEC) ? FIELD_MIN : FIELD_SEC;
                        blink_cnt <= BLINK_LOAD;
                        blink_odd <= 1'b0;
                        blank     <= '0;
                    end else if (blink_cnt == '0) begin
                        blink_cnt <= BLINK_LOAD;
                        blink_odd <= !blink_odd;
                        blank     <= blink_odd ? 4'b0000 : field_mask(field);
                    end else begin
                        blink_cnt <= blink_cnt - 1'b1;
                        blank     <= blink_odd ? field_mask(field) : 4'b0000;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    blank   <= '0;
                end
            endcase
        end
    end

    assign bus.tens_minutes = min_tens;
    assign bus.ones_minutes = min_ones;
    assign bus.tens_seconds = sec_tens;
    assign bus.ones_seconds = sec_ones;
    assign bus.blank        = blank;
    assign bus.running      = running;
    assign bus.rollover     = rollover;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_HZ=10, BLINK_HALF=3, MAX_MIN=59.
module tb_stopwatch_ctrl;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    localparam logic [4:0] P_CLR = 5'b10000;
    localparam logic [4:0] P_ADJ = 5'b01000;
    localparam logic [4:0] P_SS  = 5'b00100;
    localparam logic [4:0] P_SEL = 5'b00010;
    localparam logic [4:0] P_INC = 5'b00001;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.CLK_HZ(10), .BLINK_HALF(3), .MAX_MIN(59)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cur_time();
        return {bus.tens_minutes, bus.ones_minutes, bus.tens_seconds, bus.ones_seconds};
    endfunction

    function automatic logic [15:0] bcd_time(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a set of button pulses for exactly one clock edge.
    task automatic pulse(input logic [4:0] m);
        {bus.clear, bus.adjust, bus.start_stop, bus.sel, bus.inc} = m;
        @(negedge clk);
        {bus.clear, bus.adjust, bus.start_stop, bus.sel, bus.inc} = '0;
    endtask

    task automatic test_reset();
        tests_run++; if (cur_time() !== 16'h0000) begin tests_failed++; $display("FAIL reset_time got %h want 0000", cur_time()); end
        tests_run++; if ({bus.blank, bus.running, bus.rollover} !== 6'b0) begin tests_failed++; $display("FAIL reset_flags got %b want 000000", {bus.blank, bus.running, bus.rollover}); end
        pulse(P_SS);
        step(70);
        tests_run++; if (cur_time() !== 16'h0007 || bus.running !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_run got %h/%b want 0007/1", cur_time(), bus.running); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if (cur_time() !== 16'h0000) begin tests_failed++; $display("FAIL async_reset_time got %h want 0000", cur_time()); end
        tests_run++; if ({bus.blank, bus.running, bus.rollover} !== 6'b0) begin tests_failed++; $display("FAIL async_reset_flags got %b want 000000", {bus.blank, bus.running, bus.rollover}); end
        @(negedge clk);
        reset = 1'b1;
        step(25);
        tests_run++; if (cur_time() !== 16'h0000 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got %h/%b want 0000/0", cur_time(), bus.running); end
    endtask

    task automatic test_run_minute();
        pulse(P_SS);
        for (int i = 0; i < 60; i++) begin
            step(9);
            tests_run++; if (bus.ones_seconds !== 4'(i % 10)) begin tests_failed++; $display("FAIL hold_before_tick i=%0d got %h want %h", i, bus.ones_seconds, 4'(i % 10)); end
            step(1);
            tests_run++; if (cur_time() !== bcd_time((i + 1) / 60, (i + 1) % 60)) begin tests_failed++; $display("FAIL tick_step i=%0d got %h want %h", i, cur_time(), bcd_time((i + 1) / 60, (i + 1) % 60)); end
        end
        tests_run++; if (cur_time() !== 16'h0100 || bus.running !== 1'b1) begin tests_failed++; $display("FAIL one_minute got %h/%b want 0100/1", cur_time(), bus.running); end
        pulse(P_CLR);
        tests_run++; if (cur_time() !== 16'h0000 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL clear_in_run got %h/%b want 0000/0", cur_time(), bus.running); end
    endtask

    task automatic test_rollover();
        pulse(P_ADJ);
        repeat (58) pulse(P_INC);
        tests_run++; if (cur_time() !== 16'h0058) begin tests_failed++; $display("FAIL preload_sec got %h want 0058", cur_time()); end
        pulse(P_SEL);
        repeat (59) pulse(P_INC);
        tests_run++; if (cur_time() !== 16'h5958) begin tests_failed++; $display("FAIL preload_min got %h want 5958", cur_time()); end
        pulse(P_ADJ);
        pulse(P_SS);
        step(19);
        tests_run++; if (cur_time() !== 16'h5959 || bus.rollover !== 1'b0) begin tests_failed++; $display("FAIL pre_rollover got %h/%b want 5959/0", cur_time(), bus.rollover); end
        step(1);
        tests_run++; if (cur_time() !== 16'h0000 || bus.rollover !== 1'b1 || bus.running !== 1'b1) begin tests_failed++; $display("FAIL rollover got %h/%b/%b want 0000/1/1", cur_time(), bus.rollover, bus.running); end
        step(1);
        tests_run++; if (bus.rollover !== 1'b0) begin tests_failed++; $display("FAIL rollover_width got %b want 0", bus.rollover); end
        pulse(P_CLR);
    endtask

    task automatic test_pause_resume();
        pulse(P_SS);
        step(15);
        tests_run++; if (cur_time() !== 16'h0001) begin tests_failed++; $display("FAIL run_15 got %h want 0001", cur_time()); end
        pulse(P_SS);
        tests_run++; if (bus.running !== 1'b0) begin tests_failed++; $display("FAIL pause_running got %b want 0", bus.running); end
        step(20);
        tests_run++; if (cur_time() !== 16'h0001) begin tests_failed++; $display("FAIL pause_hold got %h want 0001", cur_time()); end
        pulse(P_SS);
        step(4);
        tests_run++; if (cur_time() !== 16'h0001 || bus.running !== 1'b1) begin tests_failed++; $display("FAIL resume_early got %h/%b want 0001/1", cur_time(), bus.running); end
        step(1);
        tests_run++; if (cur_time() !== 16'h0002) begin tests_failed++; $display("FAIL resume_tick got %h want 0002", cur_time()); end
        pulse(P_CLR);
        tests_run++; if (cur_time() !== 16'h0000 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL clear_idle got %h/%b want 0000/0", cur_time(), bus.running); end
        pulse(P_SS);
        step(9);
        tests_run++; if (cur_time() !== 16'h0000) begin tests_failed++; $display("FAIL presc_zeroed_early got %h want 0000", cur_time()); end
        step(1);
        tests_run++; if (cur_time() !== 16'h0001) begin tests_failed++; $display("FAIL presc_zeroed_tick got %h want 0001", cur_time()); end
        pulse(P_CLR);
    endtask

    task automatic test_adjust();
        pulse(P_ADJ);
        tests_run++; if (bus.blank !== 4'b0000 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL adj_entry got %b/%b want 0000/0", bus.blank, bus.running); end
        step(3);
        tests_run++; if (bus.blank !== 4'b0011) begin tests_failed++; $display("FAIL blink_sec_on got %b want 0011", bus.blank); end
        step(2);
        tests_run++; if (bus.blank !== 4'b0011) begin tests_failed++; $display("FAIL blink_sec_hold got %b want 0011", bus.blank); end
        step(1);
        tests_run++; if (bus.blank !== 4'b0000) begin tests_failed++; $display("FAIL blink_sec_off got %b want 0000", bus.blank); end
        step(3);
        repeat (3) pulse(P_INC);
        tests_run++; if (cur_time() !== 16'h0003 || bus.blank !== 4'b0000) begin tests_failed++; $display("FAIL inc_sec got %h/%b want 0003/0000", cur_time(), bus.blank); end
        pulse(P_SEL);
        step(3);
        tests_run++; if (bus.blank !== 4'b1100) begin tests_failed++; $display("FAIL blink_min_on got %b want 1100", bus.blank); end
        step(3);
        tests_run++; if (bus.blank !== 4'b0000) begin tests_failed++; $display("FAIL blink_min_off got %b want 0000", bus.blank); end
        repeat (60) pulse(P_INC);
        tests_run++; if (cur_time() !== 16'h0003) begin tests_failed++; $display("FAIL min_wrap got %h want 0003", cur_time()); end
        pulse(P_INC);
        tests_run++; if (cur_time() !== 16'h0103) begin tests_failed++; $display("FAIL inc_min got %h want 0103", cur_time()); end
        step(3);
        tests_run++; if (bus.blank !== 4'b1100) begin tests_failed++; $display("FAIL blink_after_inc got %b want 1100", bus.blank); end
        pulse(P_ADJ);
        step(12);
        tests_run++; if (cur_time() !== 16'h0103 || bus.blank !== 4'b0000 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL adj_exit got %h/%b/%b want 0103/0000/0", cur_time(), bus.blank, bus.running); end
        pulse(P_CLR);
    endtask

    task automatic test_simultaneous();
        pulse(P_SS);
        step(12);
        pulse(P_SS);
        pulse(P_CLR | P_SS);
        step(3);
        tests_run++; if (cur_time() !== 16'h0000 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL clear_over_ss got %h/%b want 0000/0", cur_time(), bus.running); end
        pulse(P_ADJ | P_SS);
        step(3);
        tests_run++; if (bus.blank !== 4'b0011 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL adj_over_ss got %b/%b want 0011/0", bus.blank, bus.running); end
        pulse(P_ADJ | P_INC);
        tests_run++; if (cur_time() !== 16'h0000 || bus.blank !== 4'b0000) begin tests_failed++; $display("FAIL adj_over_inc got %h/%b want 0000/0000", cur_time(), bus.blank); end
        pulse(P_ADJ);
        repeat (2) pulse(P_INC);
        pulse(P_CLR);
        tests_run++; if (cur_time() !== 16'h0000) begin tests_failed++; $display("FAIL clear_in_adj got %h want 0000", cur_time()); end
        step(2);
        tests_run++; if (bus.blank !== 4'b0011) begin tests_failed++; $display("FAIL stay_adj got %b want 0011", bus.blank); end
        pulse(P_ADJ);
        pulse(P_CLR);
    endtask

    task automatic test_back_to_back();
        pulse(P_SS);
        step(9);
        pulse(P_SS);
        tests_run++; if (cur_time() !== 16'h0001 || bus.running !== 1'b0) begin tests_failed++; $display("FAIL tick_and_pause got %h/%b want 0001/0", cur_time(), bus.running); end
        step(20);
        tests_run++; if (cur_time() !== 16'h0001) begin tests_failed++; $display("FAIL pause_after_tick got %h want 0001", cur_time()); end
        pulse(P_SS);
        step(9);
        tests_run++; if (cur_time() !== 16'h0001) begin tests_failed++; $display("FAIL resume_from_zero_early got %h want 0001", cur_time()); end
        step(1);
        tests_run++; if (cur_time() !== 16'h0002) begin tests_failed++; $display("FAIL resume_from_zero got %h want 0002", cur_time()); end
        pulse(P_CLR);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        {bus.clear, bus.adjust, bus.start_stop, bus.sel, bus.inc} = '0;
        step(2);
        reset = 1'b1;
        step(1);
        test_reset();
        test_run_minute();
        test_rollover();
        test_pause_resume();
        test_adjust();
        test_simultaneous();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
